// File: rtl/w_event_counter.sv
// Rising-edge event tally in packed BCD with a req/ack snapshot port for slow readers.
// Optional macro EVT_SATURATE_EN: hold at all nines on overflow instead of wrapping to zero.
module w_event_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  count_in,
    input  logic                  clear,
    input  logic                  snap_req,
    input  logic                  snap_ack,
    output logic [4*DIGITS-1:0]   bcd_count,
    output logic                  event_pulse,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   snap_value,
    output logic                  snap_valid
);

    localparam int W = 4 * DIGITS;

    typedef enum logic {
        SNAP_IDLE = 1'b0,
        SNAP_HOLD = 1'b1
    } snap_state_t;

    snap_state_t  snap_state_r;
    logic         count_d_r;
    logic         event_s;
    logic [W-1:0] inc_value_s;
    logic         inc_carry_s;

    // Increment a packed-BCD value; the MSB of the result is set when every digit was nine.
    function automatic logic [W:0] bcd_inc(input logic [W-1:0] value);
        logic [W-1:0] result;
        logic         carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value[4*i +: 4] >= 4'd9) begin
                    result[4*i +: 4] = 4'd0;
                end else begin
                    result[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end else begin
                result[4*i +: 4] = value[4*i +: 4];
            end
        end
        return {carry, result};
    endfunction

    assign event_s = count_in & ~count_d_r;

    // Next counter value and wrap indication from the current count.
    always_comb begin
        {inc_carry_s, inc_value_s} = bcd_inc(bcd_count);
    end

    // Edge detector, counter, overflow flag and event pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_d_r   <= 1'b0;
            bcd_count   <= {W{1'b0}};
            overflow    <= 1'b0;
            event_pulse <= 1'b0;
        end else begin
            count_d_r   <= count_in;
            event_pulse <= event_s;
            // Clear beats a coincident event; that event is dropped but still pulses.
            if (clear) begin
                bcd_count <= {W{1'b0}};
                overflow  <= 1'b0;
            end else if (event_s) begin
                if (inc_carry_s) begin
                    overflow <= 1'b1;
`ifdef EVT_SATURATE_EN
                    bcd_count <= bcd_count;
`else
                    bcd_count <= inc_value_s;
`endif
                end else begin
                    bcd_count <= inc_value_s;
                end
            end else begin
                bcd_count <= bcd_count;
            end
        end
    end

    // Snapshot handshake: capture the pre-edge count on request, hold until acknowledged.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            snap_state_r <= SNAP_IDLE;
            snap_value   <= {W{1'b0}};
            snap_valid   <= 1'b0;
        end else begin
            case (snap_state_r)
                SNAP_IDLE: begin
                    if (snap_req) begin
                        snap_state_r <= SNAP_HOLD;
                        snap_value   <= bcd_count;
                        snap_valid   <= 1'b1;
                    end else begin
                        snap_valid   <= 1'b0;
                    end
                end
                SNAP_HOLD: begin
                    if (snap_ack) begin
                        snap_state_r <= SNAP_IDLE;
                        snap_valid   <= 1'b0;
                    end else begin
                        snap_valid   <= 1'b1;
                    end
                end
                default: begin
                    snap_state_r <= SNAP_IDLE;
                    snap_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_w_event_counter.sv
// Directed self-checking bench for w_event_counter (DIGITS=2).
module tb_w_event_counter;

    logic       clock;
    logic       resetn;
    logic       count_in;
    logic       clear;
    logic       snap_req;
    logic       snap_ack;
    logic [7:0] bcd_count;
    logic       event_pulse;
    logic       overflow;
    logic [7:0] snap_value;
    logic       snap_valid;

    int errors = 0;
    int checks = 0;
    int pulse_total = 0;

    w_event_counter #(.DIGITS(2)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .count_in    (count_in),
        .clear       (clear),
        .snap_req    (snap_req),
        .snap_ack    (snap_ack),
        .bcd_count   (bcd_count),
        .event_pulse (event_pulse),
        .overflow    (overflow),
        .snap_value  (snap_value),
        .snap_valid  (snap_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (event_pulse === 1'b1) pulse_total = pulse_total + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ev(input int h);
        count_in = 1'b1;
        tick(h);
        count_in = 1'b0;
        tick(1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; count_in = 1'b1; clear = 1'b0; snap_req = 1'b0; snap_ack = 1'b0;
        #12;
        checks++;
        if ({bcd_count, event_pulse, overflow, snap_value, snap_valid} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {bcd_count, event_pulse, overflow, snap_value, snap_valid});
        end
        #1 resetn = 1'b1;
        tick(1);
        checks++;
        if (bcd_count !== 8'h01 || event_pulse !== 1'b1) begin
            errors++;
            $display("FAIL first_edge got=%h/%b exp=01/1", bcd_count, event_pulse);
        end
        tick(1);
        checks++;
        if (bcd_count !== 8'h01 || event_pulse !== 1'b0) begin
            errors++;
            $display("FAIL held_high got=%h/%b exp=01/0", bcd_count, event_pulse);
        end
        count_in = 1'b0;
        tick(1);
    endtask

    task automatic test_count();
        int p0;
        do_clear();
        checks++;
        if (bcd_count !== 8'h00) begin
            errors++;
            $display("FAIL clear_zero got=%h exp=00", bcd_count);
        end
        p0 = pulse_total;
        for (int i = 1; i <= 12; i++) begin
            ev(((i - 1) % 5) + 1);
            if (i == 9) begin
                checks++;
                if (bcd_count !== 8'h09) begin
                    errors++;
                    $display("FAIL count_nine got=%h exp=09", bcd_count);
                end
            end
            if (i == 10) begin
                checks++;
                if (bcd_count !== 8'h10) begin
                    errors++;
                    $display("FAIL carry_ten got=%h exp=10", bcd_count);
                end
            end
        end
        checks++;
        if (bcd_count !== 8'h12) begin
            errors++;
            $display("FAIL count_twelve got=%h exp=12", bcd_count);
        end
        checks++;
        if (pulse_total - p0 !== 12) begin
            errors++;
            $display("FAIL pulse_count got=%0d exp=12", pulse_total - p0);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 99; i++) ev(1);
        checks++;
        if (bcd_count !== 8'h99 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL at_max got=%h/%b exp=99/0", bcd_count, overflow);
        end
        ev(1);
`ifdef EVT_SATURATE_EN
        checks++;
        if (bcd_count !== 8'h99 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sat got=%h/%b exp=99/1", bcd_count, overflow);
        end
        ev(1);
        checks++;
        if (bcd_count !== 8'h99 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold got=%h/%b exp=99/1", bcd_count, overflow);
        end
`else
        checks++;
        if (bcd_count !== 8'h00 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_wrap got=%h/%b exp=00/1", bcd_count, overflow);
        end
        ev(1);
        checks++;
        if (bcd_count !== 8'h01 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky got=%h/%b exp=01/1", bcd_count, overflow);
        end
`endif
        do_clear();
        checks++;
        if (bcd_count !== 8'h00 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_overflow got=%h/%b exp=00/0", bcd_count, overflow);
        end
    endtask

    task automatic test_clear_event();
        do_clear();
        for (int i = 0; i < 5; i++) ev(1);
        checks++;
        if (bcd_count !== 8'h05) begin
            errors++;
            $display("FAIL pre_clear got=%h exp=05", bcd_count);
        end
        count_in = 1'b1;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        count_in = 1'b0;
        checks++;
        if (bcd_count !== 8'h00 || overflow !== 1'b0 || event_pulse !== 1'b1) begin
            errors++;
            $display("FAIL clear_wins got=%h/%b/%b exp=00/0/1", bcd_count, overflow, event_pulse);
        end
        tick(1);
    endtask

    task automatic test_snapshot();
        do_clear();
        for (int i = 0; i < 7; i++) ev(1);
        snap_req = 1'b1;
        count_in = 1'b1;
        tick(1);
        snap_req = 1'b0;
        count_in = 1'b0;
        checks++;
        if (snap_value !== 8'h07 || snap_valid !== 1'b1 || bcd_count !== 8'h08) begin
            errors++;
            $display("FAIL snap_capture got=%h/%b/%h exp=07/1/08", snap_value, snap_valid, bcd_count);
        end
        tick(1);
        ev(1);
        checks++;
        if (bcd_count !== 8'h09 || snap_value !== 8'h07) begin
            errors++;
            $display("FAIL snap_frozen got=%h/%h exp=09/07", bcd_count, snap_value);
        end
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        checks++;
        if (snap_value !== 8'h07 || snap_valid !== 1'b1) begin
            errors++;
            $display("FAIL snap_req_ignored got=%h/%b exp=07/1", snap_value, snap_valid);
        end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++;
        if (bcd_count !== 8'h00 || snap_value !== 8'h07 || snap_valid !== 1'b1) begin
            errors++;
            $display("FAIL snap_clear_indep got=%h/%h/%b exp=00/07/1", bcd_count, snap_value, snap_valid);
        end
        snap_ack = 1'b1;
        tick(1);
        snap_ack = 1'b0;
        checks++;
        if (snap_valid !== 1'b0) begin
            errors++;
            $display("FAIL snap_ack got=%b exp=0", snap_valid);
        end
        ev(1);
        ev(1);
        snap_ack = 1'b1;
        tick(1);
        snap_ack = 1'b0;
        checks++;
        if (snap_valid !== 1'b0 || snap_value !== 8'h07) begin
            errors++;
            $display("FAIL ack_in_idle got=%b/%h exp=0/07", snap_valid, snap_value);
        end
        snap_req = 1'b1;
        tick(1);
        snap_ack = 1'b1;
        tick(1);
        snap_req = 1'b0;
        snap_ack = 1'b0;
        checks++;
        if (snap_valid !== 1'b0 || snap_value !== 8'h02) begin
            errors++;
            $display("FAIL req_ack_same got=%b/%h exp=0/02", snap_valid, snap_value);
        end
        tick(1);
        checks++;
        if (snap_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_recapture got=%b exp=0", snap_valid);
        end
    endtask

    task automatic test_async_reset();
        ev(1);
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        checks++;
        if (snap_valid !== 1'b1 || bcd_count !== 8'h03) begin
            errors++;
            $display("FAIL hold_before_reset got=%b/%h exp=1/03", snap_valid, bcd_count);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (snap_valid !== 1'b0 || bcd_count !== 8'h00 || snap_value !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got=%b/%h/%h exp=0/00/00", snap_valid, bcd_count, snap_value);
        end
        #1 resetn = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_count();
        test_overflow();
        test_clear_event();
        test_snapshot();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
